// File: rtl/vga_pkg.sv
// vga_pkg
//   Display timing constants shared by vga_sync and the frame-buffer arbiter,
//   frame-buffer defaults, and the arbiter FSM state encoding.
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixel clocks / lines
    localparam int VGA_H_VIDEO = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIDEO + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_VIDEO = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIDEO + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Frame-buffer defaults
    localparam int FB_ADDR_W     = 19;
    localparam int FB_DATA_W     = 8;
    localparam int FB_FIFO_DEPTH = 16;
    localparam int FB_LOW_WM     = 4;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } fb_state_t;

    // Number of RAM words scanned out per frame
    function automatic int fb_frame_words(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo
//   Synchronous pixel FIFO with flush. Head word is visible combinationally
//   on o_rdata; a pop advances past it. Push while full and pop while empty
//   are ignored; flush dominates push/pop.
// Ports
//   i_clk, i_rst_n   clock, async active-low reset
//   i_flush          empty the FIFO this cycle
//   i_push, i_wdata  write a word
//   i_pop            consume head word
//   o_rdata          head word
//   o_level          occupancy 0..DEPTH
//   o_empty          occupancy == 0
module vga_pix_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_push  = i_push && !w_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port pixel RAM between display scanout and a drawing
//   writer. A prefetch FIFO is kept topped up from a linear fetch counter;
//   when committed occupancy drops below LOW_WM the fetch pre-empts the
//   writer, otherwise the writer wins over a plain top-up fetch.
// Ports
//   i_clk, i_rst_n         pixel clock, async active-low reset
//   i_pixel_y, i_video_on  position/active flag from vga_sync
//   i_wr_valid/o_wr_ready  writer handshake, i_wr_addr/i_wr_data payload
//   o_mem_*                RAM strobe/we/address/write data (combinational)
//   i_mem_rdata            RAM read data, one cycle after a read strobe
//   o_pix_data             scanout pixel, one cycle after i_video_on
//   o_underflow            sticky starvation flag, cleared at frame start
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int H_VIDEO    = VGA_H_VIDEO,
    parameter int V_VIDEO    = VGA_V_VIDEO,
    parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
    parameter int LOW_WM     = FB_LOW_WM
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_pixel_y,
    input  logic              i_video_on,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_underflow
);

    localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(fb_frame_words(H_VIDEO, V_VIDEO));

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    logic [9:0]        r_prev_y;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_rd_inflight;
    logic [DATA_W-1:0] r_pix_data;
    logic              r_underflow;

    logic              w_frame_start;
    logic              w_flush;
    logic              w_run;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W:0]    w_committed;
    logic              w_room;
    logic              w_can_fetch;
    logic              w_urgent;
    logic              w_grant_fetch;
    logic              w_grant_write;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    assign w_flush = (r_state == ST_FLUSH);
    assign w_run   = (r_state == ST_RUN);

    // Frame start: previous line was the last active one and the new line
    // is past the active area.
    assign w_frame_start = (r_prev_y == 10'(V_VIDEO - 1)) && (i_pixel_y >= 10'(V_VIDEO));

    // Words already in the FIFO plus the one on its way back from the RAM
    assign w_committed   = {1'b0, w_level} + {{LVL_W{1'b0}}, r_rd_inflight};
    assign w_room        = (w_committed < (LVL_W + 1)'(FIFO_DEPTH));
    assign w_can_fetch   = w_run && w_room && (r_fetch_addr < FRAME_WORDS);
    assign w_urgent      = w_can_fetch && (w_committed < (LVL_W + 1)'(LOW_WM));
    assign w_grant_fetch = w_can_fetch && (w_urgent || !i_wr_valid);
    assign w_grant_write = w_run && i_wr_valid && !w_grant_fetch;

    // No RAM access is granted in FLUSH, so the only read that can be
    // outstanding when the flush starts returns during FLUSH itself; gating
    // the push on RUN is what drops it.
    assign w_push = r_rd_inflight && w_run;
    assign w_pop  = w_run && i_video_on && !w_empty;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_wr_ready  = 1'b0;
        if (w_grant_fetch) begin
            o_mem_en   = 1'b1;
            o_mem_addr = r_fetch_addr;
        end else if (w_grant_write) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
            o_wr_ready  = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FLUSH: w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_FLUSH;
        endcase
        if (w_frame_start) w_state_nxt = ST_FLUSH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_FLUSH;
            r_prev_y      <= '0;
            r_fetch_addr  <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_y      <= i_pixel_y;
            r_rd_inflight <= w_grant_fetch;
            if (w_flush)
                r_fetch_addr <= '0;
            else if (w_grant_fetch)
                r_fetch_addr <= r_fetch_addr + 1'b1;
        end
    end

    // Scanout: one pop per active cycle; starvation outputs black and
    // latches underflow until the next flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_data  <= '0;
            r_underflow <= 1'b0;
        end else if (w_flush) begin
            r_pix_data  <= '0;
            r_underflow <= 1'b0;
        end else if (i_video_on) begin
            if (!w_empty) begin
                r_pix_data <= w_head;
            end else begin
                r_pix_data  <= '0;
                r_underflow <= 1'b1;
            end
        end else begin
            r_pix_data <= '0;
        end
    end

    assign o_pix_data  = r_pix_data;
    assign o_underflow = r_underflow;

    vga_pix_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (i_mem_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a reduced 16x8 frame. A RAM model answers the
// DUT; a queue-based reference model predicts every RAM grant, pixel and the
// underflow flag from the arbitration rules.
module tb_vga_fb_arbiter;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int DEPTH = 16;
    localparam int LWM   = 4;
    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    pixel_y;
    logic          video_on;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] pix_data;
    logic          underflow;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .H_VIDEO(H), .V_VIDEO(V),
        .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pixel_y(pixel_y), .i_video_on(video_on),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_pix_data(pix_data), .o_underflow(underflow)
    );

    // RAM seen by the DUT
    logic [DW-1:0] ram [2048];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[10:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[10:0]];
        end
    end

    // Reference model state
    logic [DW-1:0] m_ram [2048];
    logic [DW-1:0] q[$];
    bit            m_run;
    bit            m_infl;
    logic [DW-1:0] m_infl_d;
    int            m_fa;
    int            m_prev_y;
    logic [DW-1:0] m_pix;
    bit            m_uf;
    bit            m_wgrant;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_reads;
    bit            last_rd;
    logic [AW-1:0] last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_infl = 0; m_infl_d = '0; m_fa = 0; m_prev_y = 0;
        m_pix = '0; m_uf = 0; m_wgrant = 0;
    endtask

    // One clock: check at the falling edge, advance the model, then let the
    // rising edge happen and return 1 time unit after it.
    task automatic step();
        int lvl;
        bit fs, canf, urg, f, w, ret_v;
        logic [DW-1:0] ret;
        @(negedge clk);
        last_rd   = mem_en && !mem_we;
        last_addr = mem_addr;
        if (last_rd) n_reads++;
        if (!rst_n) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_pix", pix_data, 0);
            chk("rst_uflow", underflow, 0);
            model_reset();
        end else begin
            chk("pix", pix_data, m_pix);
            chk("uflow", underflow, m_uf);
            lvl  = q.size() + int'(m_infl);
            fs   = (m_prev_y == V - 1) && (int'(pixel_y) >= V);
            canf = m_run && lvl < DEPTH && m_fa < TOTAL;
            urg  = canf && lvl < LWM;
            f    = canf && (urg || !wr_valid);
            w    = m_run && wr_valid && !f;
            chk("mem_en", mem_en, f || w);
            chk("mem_we", mem_we, w);
            chk("wr_ready", wr_ready, w);
            if (f) chk("rd_addr", mem_addr, m_fa);
            if (w) begin
                chk("wr_addr", mem_addr, wr_addr);
                chk("wr_data", mem_wdata, wr_data);
            end
            ret = m_infl_d; ret_v = m_infl;
            if (!m_run) begin
                q.delete(); m_fa = 0; m_pix = '0; m_uf = 0; m_infl = 0;
            end else begin
                if (video_on) begin
                    if (q.size() > 0) m_pix = q.pop_front();
                    else begin m_pix = '0; m_uf = 1; end
                end else m_pix = '0;
                if (ret_v) q.push_back(ret);
                if (f) begin m_infl = 1; m_infl_d = m_ram[m_fa]; m_fa++; end
                else m_infl = 0;
                if (w) m_ram[wr_addr[10:0]] = wr_data;
            end
            m_run    = !fs;
            m_prev_y = int'(pixel_y);
            m_wgrant = w;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: idle, 1: always requesting, 2: random on/off. A pending
    // request is held stable until granted.
    task automatic drive_wr(input int mode);
        if (mode == 0) wr_valid = 1'b0;
        else if (wr_valid && !m_wgrant) ;
        else begin
            wr_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            wr_addr  = AW'(1024 + $urandom_range(0, 1023));
            wr_data  = DW'($urandom);
        end
    endtask

    initial begin
        bit found;
        int idx;
        for (int i = 0; i < 2048; i++) begin
            ram[i]   = DW'(i);
            m_ram[i] = DW'(i);
        end
        rst_n = 1'b0; pixel_y = 10'd490; video_on = 1'b0;
        wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA;
        model_reset();

        // Reset state, with a writer request present
        repeat (3) step();
        wr_valid = 1'b0;
        rst_n = 1'b1;

        // Blank fill: exactly 16 reads, then idle
        n_reads = 0;
        repeat (24) step();
        chk("fill_reads", n_reads, 16);
        chk("full_idle_en", mem_en, 0);

        // Writer streams while the FIFO is full
        repeat (12) begin drive_wr(1); step(); end

        // Reset in the middle of traffic, then random mix
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (10) begin drive_wr(2); step(); end

        // Full frame: frame start, three blank lines, eight active lines
        pixel_y = 10'(V - 1); drive_wr(2); step();
        for (int y = V; y < V + 3; y++)
            for (int x = 0; x < H + 6; x++) begin
                pixel_y = 10'(y); video_on = 1'b0; drive_wr(2); step();
            end
        idx = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H + 6; x++) begin
                pixel_y = 10'(y); video_on = (x < H); drive_wr(2); step();
                if (video_on) begin
                    chk("scan_seq", pix_data, DW'(idx));
                    idx++;
                end
            end
        video_on = 1'b0;
        chk("frame_uflow", underflow, 0);

        // Starve: frame fully fetched and drained, keep video_on
        drive_wr(0);
        pixel_y = 10'(V - 1);
        video_on = 1'b1;
        repeat (4) begin
            step();
            chk("stall_pix", pix_data, 0);
            chk("stall_uflow", underflow, 1);
        end
        video_on = 1'b0;
        repeat (4) begin step(); chk("uflow_sticky", underflow, 1); end

        // Frame start clears underflow and restarts fetch at 0
        pixel_y = 10'(V); step();
        pixel_y = 10'(V - 1); step();
        chk("uflow_clr", underflow, 0);

        // Frame start the cycle after the read of address 5
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (last_rd && last_addr == AW'(5)) found = 1;
        end
        chk("rd5_seen", found, 1);
        pixel_y = 10'(V); step();
        pixel_y = 10'(V + 1);
        repeat (30) step();
        pixel_y = 10'd0; video_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("restart_px", pix_data, DW'(k));
        end
        video_on = 1'b0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
